// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the integer register file and its write scoreboard.
package regfile_sb_pkg;
  localparam int NREG  = 32;
  localparam int AW    = $clog2(NREG);
  localparam int PENDW = 2;
  localparam int DW    = 64;
  localparam logic [PENDW-1:0] CNT_MAX = '1;

  typedef logic [AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating pending-write counter for one architectural register.
// REGFILE_BYPASS_EN: busy drops in the cycle the last outstanding write lands.
module regfile_sb_cnt
  import regfile_sb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_busy,
  output logic o_full
);
  logic [PENDW-1:0] cnt;
  logic             nz;

  assign nz     = (cnt != '0);
  assign o_full = (cnt == CNT_MAX);
`ifdef REGFILE_BYPASS_EN
  assign o_busy = nz && !((cnt == PENDW'(1)) && i_dec);
`else
  assign o_busy = nz;
`endif

  // Simultaneous inc and dec cancel; dec at zero is an unreserved writeback and holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                        cnt <= '0;
    else if (i_clr)                      cnt <= '0;
    else if (i_inc && !i_dec && !o_full) cnt <= cnt + PENDW'(1);
    else if (i_dec && !i_inc && nz)      cnt <= cnt - PENDW'(1);
  end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard; x0 is hardwired zero and untracked.
// REGFILE_BYPASS_EN: forward same-cycle writeback data to the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_idx,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_iss_valid,
  input  logic          i_iss_rdwen,
  input  logic [AW-1:0] i_iss_rdidx,
  output logic          o_iss_ready,
  input  logic [AW-1:0] i_rs1_idx,
  input  logic [AW-1:0] i_rs2_idx,
  output logic [DW-1:0] o_rs1_data,
  output logic [DW-1:0] o_rs2_data,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy,
  input  logic          i_flush
);
  logic [NREG-1:0][DW-1:0] regs;
  logic [NREG-1:0]         busy;
  logic [NREG-1:0]         full;
  logic                    fire;

  assign busy[0] = 1'b0;
  assign full[0] = 1'b0;

  // Ready looks at the registered count only, so a same-cycle writeback never frees a slot.
  assign o_iss_ready = !full[i_iss_rdidx] || !i_iss_rdwen || (i_iss_rdidx == '0);
  assign fire        = i_iss_valid && i_iss_rdwen && o_iss_ready && (i_iss_rdidx != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    regfile_sb_cnt u_cnt (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_inc  (fire && (i_iss_rdidx == reg_idx_t'(r))),
      .i_dec  (i_wb_en && (i_wb_idx == reg_idx_t'(r))),
      .i_clr  (i_flush),
      .o_busy (busy[r]),
      .o_full (full[r])
    );
  end

  // Writeback data commits even under flush; only reset suppresses it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                         regs <= '0;
    else if (i_wb_en && i_wb_idx != '0)   regs[i_wb_idx] <= i_wb_data;
  end

  always_comb begin
    o_rs1_data = (i_rs1_idx == '0) ? '0 : regs[i_rs1_idx];
    o_rs2_data = (i_rs2_idx == '0) ? '0 : regs[i_rs2_idx];
`ifdef REGFILE_BYPASS_EN
    if (i_wb_en && i_wb_idx == i_rs1_idx && i_rs1_idx != '0) o_rs1_data = i_wb_data;
    if (i_wb_en && i_wb_idx == i_rs2_idx && i_rs2_idx != '0) o_rs2_data = i_wb_data;
`endif
    o_rs1_busy = busy[i_rs1_idx];
    o_rs2_busy = busy[i_rs2_idx];
  end
endmodule
